conv_enc_punct: RTL and testbench

Parametrised successor to the rate-1/2 convolutional encoder. Rate 1/R, constraint length K, with runtime-loadable generator polynomials and a runtime-loadable puncture pattern (period P). Frames are zero-terminated automatically with K-1 tail bits. Streaming valid/ready input and a serialised one-bit valid/ready output with a last flag. Sits between the framer and the modulator bit interface.

---
 rtl/conv_enc_pkg.sv | 19 +
 rtl/conv_enc_punct_cw.sv | 21 ++
 rtl/conv_enc_punct.sv | 144 ++++++++++++++
 tb/tb_conv_enc_punct.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types and helpers for the parametrised convolutional encoder.
package conv_enc_pkg;

  typedef enum logic [1:0] {ACCEPT, EMIT, TAIL} enc_state_t;

  localparam logic [31:0] GEN_ALL_ONES = '1;

  // Parity of the tapped window bits; only the low `width` bits take part.
  function automatic logic parity(input logic [31:0] gen, input logic [31:0] window,
                                  input int unsigned width);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) p = p ^ (gen[i] & window[i]);
    end
    return p;
  endfunction

endpackage

// File: rtl/conv_enc_punct_cw.sv
// Combinational codeword generator: one parity bit per generator over {b, sr}.
module conv_enc_cw
  import conv_enc_pkg::*;
#(
  parameter int K = 4,
  parameter int R = 2
) (
  input  logic [K-2:0]          sr,
  input  logic                  b,
  input  logic [R-1:0][K-1:0]   gens,
  output logic [R-1:0]          c
);

  always_comb begin
    c = '0;
    for (int unsigned j = 0; j < R; j++) begin
      c[j] = parity(32'(gens[j]), 32'({b, sr}), K);
    end
  end

endmodule

// File: rtl/conv_enc_punct.sv
// Rate-1/R convolutional encoder with loadable generators, puncturing,
// automatic zero termination and a serialised one-bit output stream.
module conv_enc_punct
  import conv_enc_pkg::*;
#(
  parameter int K = 4,
  parameter int R = 2,
  parameter int P = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gen_we,
  input  logic [$clog2(R)-1:0]  gen_sel,
  input  logic [K-1:0]          gen_data,
  input  logic                  punct_we,
  input  logic [R*P-1:0]        punct_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int JW = $clog2(R);
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int TW = $clog2(K);

  enc_state_t             state;
  logic [K-2:0]           sr;
  logic [R-1:0][K-1:0]    gens;
  logic [P-1:0][R-1:0]    punct;
  logic [PW-1:0]          col;
  logic [JW-1:0]          j;
  logic [JW-1:0]          j_nxt;
  logic [TW-1:0]          tail_cnt;
  logic [R-1:0]           cw;
  logic [R-1:0]           c;
  logic                   is_last;
  logic                   is_tail;
  logic                   b;
  logic                   final_cw;

  always_comb begin
    b        = (state == TAIL) ? 1'b0 : in_data;
    j_nxt    = j + 1'b1;
    final_cw = is_tail && (tail_cnt == TW'(K-1));
  end

  conv_enc_cw #(.K(K), .R(R)) u_cw (
    .sr   (sr),
    .b    (b),
    .gens (gens),
    .c    (c)
  );

  // Outputs are registered: each transition also preloads the flags for the
  // position the next cycle will present.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCEPT;
      sr        <= '0;
      gens      <= {R{GEN_ALL_ONES[K-1:0]}};
      punct     <= '1;
      col       <= '0;
      j         <= '0;
      tail_cnt  <= '0;
      cw        <= '0;
      is_last   <= 1'b0;
      is_tail   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (gen_we && (32'(gen_sel) < R)) gens[gen_sel] <= gen_data;
      if (punct_we) punct <= punct_data;

      case (state)
        ACCEPT: begin
          if (in_valid && in_ready) begin
            cw        <= c;
            sr        <= {in_data, sr[K-2:1]};
            is_last   <= in_last;
            is_tail   <= 1'b0;
            j         <= '0;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= punct[col][0];
            out_data  <= c[0];
            out_last  <= 1'b0;
            state     <= EMIT;
          end
        end
        TAIL: begin
          cw        <= c;
          sr        <= {1'b0, sr[K-2:1]};
          is_tail   <= 1'b1;
          tail_cnt  <= tail_cnt + 1'b1;
          j         <= '0;
          out_valid <= 1'b1;
          out_data  <= c[0];
          out_last  <= 1'b0;
          state     <= EMIT;
        end
        EMIT: begin
          if (!out_valid || out_ready) begin
            if (j == JW'(R-1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (!is_tail) col <= (col == PW'(P-1)) ? '0 : col + 1'b1;
              if (final_cw) begin
                sr       <= '0;
                col      <= '0;
                tail_cnt <= '0;
                is_last  <= 1'b0;
                is_tail  <= 1'b0;
                busy     <= 1'b0;
                in_ready <= 1'b1;
                state    <= ACCEPT;
              end else if (is_last) begin
                state <= TAIL;
              end else begin
                in_ready <= 1'b1;
                state    <= ACCEPT;
              end
            end else begin
              j         <= j_nxt;
              out_valid <= is_tail | punct[col][j_nxt];
              out_data  <= cw[j_nxt];
              out_last  <= final_cw && (j_nxt == JW'(R-1));
            end
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_punct.sv
// Scoreboard bench for conv_enc_punct against a frame-level encoding model.
module tb_conv_enc_punct;

  localparam int K = 4;
  localparam int R = 2;
  localparam int P = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 gen_we = 1'b0;
  logic [$clog2(R)-1:0] gen_sel = '0;
  logic [K-1:0]         gen_data = '0;
  logic                 punct_we = 1'b0;
  logic [R*P-1:0]       punct_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_data = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_data;
  logic                 out_last;
  logic                 busy;

  conv_enc_punct #(.K(K), .R(R), .P(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .gen_we     (gen_we),
    .gen_sel    (gen_sel),
    .gen_data   (gen_data),
    .punct_we   (punct_we),
    .punct_data (punct_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int last_hs  = -1;
  int rmode    = 0;
  int phase    = 0;

  logic [1:0]     exp_q[$];
  logic [K-1:0]   m_gen[R];
  logic [R*P-1:0] m_punct;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (phase % 3 == 0);
    endcase
    phase++;
  end

  // Frame-level model: time t carries input bit x[t] (zeros past the frame),
  // output j is the parity of x[t-d] for each generator tap d.
  task automatic push_expected(input logic [63:0] bits, input int len);
    int total;
    logic p;
    logic x;
    total = len + K - 1;
    for (int t = 0; t < total; t++) begin
      for (int jj = 0; jj < R; jj++) begin
        p = 1'b0;
        for (int d = 0; d < K; d++) begin
          x = (t - d >= 0 && t - d < len) ? bits[t-d] : 1'b0;
          if (m_gen[jj][K-1-d]) p = p ^ x;
        end
        if (t >= len || m_punct[(t % P) * R + jj])
          exp_q.push_back({p, (t == total - 1 && jj == R - 1)});
      end
    end
  endtask

  logic stalled = 1'b0;
  logic held_d, held_l;
  logic [1:0] item;

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      chk(in_ready == 1'b0, "in_ready_low_while_emit", int'(in_ready), 0);
      chk(busy == 1'b1, "busy_while_emit", int'(busy), 1);
      if (stalled)
        chk(out_data == held_d && out_last == held_l, "stable_under_stall",
            int'({out_data, out_last}), int'({held_d, held_l}));
      if (out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", int'({out_data, out_last}), -1);
        end else begin
          item = exp_q.pop_front();
          chk(out_data == item[1] && out_last == item[0], "out_bit{data,last}",
              int'({out_data, out_last}), int'(item));
          pop_cnt++;
          if (out_last) last_hs = cyc + 1;
        end
      end else begin
        stalled = 1'b1;
        held_d  = out_data;
        held_l  = out_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic load_gen(input int sel, input logic [K-1:0] g);
    gen_we = 1'b1; gen_sel = sel[$clog2(R)-1:0]; gen_data = g;
    @(posedge clk); #1;
    gen_we = 1'b0;
    m_gen[sel] = g;
  endtask

  task automatic load_punct(input logic [R*P-1:0] pm);
    punct_we = 1'b1; punct_data = pm;
    @(posedge clk); #1;
    punct_we = 1'b0;
    m_punct = pm;
  endtask

  task automatic send_frame(input logic [63:0] bits, input int len, input bit keep,
                            output int first_acc);
    int tmo;
    first_acc = -1;
    push_expected(bits, len);
    for (int n = 0; n < len; n++) begin
      tmo = 0;
      in_valid = 1'b1; in_data = bits[n]; in_last = (n == len - 1);
      while (!in_ready && tmo < 200) begin @(posedge clk); #1; tmo++; end
      if (!in_ready) chk(1'b0, "accept_timeout", tmo, 200);
      if (n == 0) first_acc = cyc + 1;
      @(posedge clk); #1;
    end
    if (!keep) begin in_valid = 1'b0; in_last = 1'b0; end
  endtask

  task automatic wait_idle();
    int tmo;
    tmo = 0;
    while (exp_q.size() != 0 && tmo < 2000) begin @(posedge clk); #1; tmo++; end
    chk(exp_q.size() == 0, "drain_pending", exp_q.size(), 0);
    chk(busy == 1'b0, "busy_clear_after_last", int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic model_defaults();
    for (int jj = 0; jj < R; jj++) m_gen[jj] = '1;
    m_punct = '1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(in_ready == 1'b1, {tag, "_in_ready"}, int'(in_ready), 1);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, int'(out_valid), 0);
    chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
  endtask

  int acc0, acc1, tmo;
  logic [63:0] rb;
  int rl;

  initial begin
    model_defaults();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_idle_outputs("reset");
    chk(out_data == 1'b0 && out_last == 1'b0, "reset_out_data_last",
        int'({out_data, out_last}), 0);

    // Reference gens 'o17 / 'o13, unpunctured single-bit frame.
    load_gen(0, 4'b1111);
    load_gen(1, 4'b1011);
    send_frame(64'b1, 1, 1'b0, acc0);
    wait_idle();

    // Puncture column 1 drops output 1.
    load_punct(4'b0111);
    send_frame(64'b11, 2, 1'b0, acc0);
    wait_idle();

    // Back-pressure with the 1-0-0 ready pattern.
    load_punct(4'b1111);
    rmode = 2;
    send_frame(64'b1, 1, 1'b0, acc0);
    wait_idle();
    rmode = 0;

    // Reset after the third output bit.
    send_frame(64'b1, 1, 1'b0, acc0);
    tmo = 0;
    while (pop_cnt < 3 + 8 + 9 + 8 && tmo < 200) begin @(posedge clk); #1; tmo++; end
    chk(tmo < 200, "midframe_wait", tmo, 200);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_defaults();
    check_idle_outputs("midframe_reset");
    send_frame(64'b1, 1, 1'b0, acc0);
    wait_idle();

    // Generator reload between frames.
    load_gen(1, 4'b1101);
    send_frame(64'b1, 1, 1'b0, acc0);
    wait_idle();

    // Back-to-back frames with in_valid held high.
    send_frame(64'b1, 1, 1'b1, acc0);
    send_frame(64'b1, 1, 1'b0, acc1);
    chk(acc1 == last_hs + 1, "b2b_accept_cycle", acc1, last_hs + 1);
    wait_idle();

    // Randomised generators, puncture patterns, frames and back-pressure.
    rmode = 1;
    for (int f = 0; f < 8; f++) begin
      for (int jj = 0; jj < R; jj++) load_gen(jj, K'($urandom));
      load_punct((R*P)'($urandom));
      rb = {$urandom, $urandom};
      rl = $urandom_range(1, 20);
      send_frame(rb, rl, 1'b0, acc0);
      wait_idle();
    end
    rmode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
